// File: rtl/aes_round_key_sequencer.sv
// AES-128 round-key sequencer: accepts a cipher key, drives it onto an external
// combinational KeyExpansionFunction, captures round keys 1..10 after a settle
// window, and streams rk0..rk10 to the round engine with replay support.
module aes_round_key_sequencer #(
    parameter int unsigned WIDTH         = 128,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    input  logic [WIDTH-1:0] key_ciph_i,
    output logic [WIDTH-1:0] kx_key_o,
    input  logic [WIDTH-1:0] kx_key_1_i,
    input  logic [WIDTH-1:0] kx_key_2_i,
    input  logic [WIDTH-1:0] kx_key_3_i,
    input  logic [WIDTH-1:0] kx_key_4_i,
    input  logic [WIDTH-1:0] kx_key_5_i,
    input  logic [WIDTH-1:0] kx_key_6_i,
    input  logic [WIDTH-1:0] kx_key_7_i,
    input  logic [WIDTH-1:0] kx_key_8_i,
    input  logic [WIDTH-1:0] kx_key_9_i,
    input  logic [WIDTH-1:0] kx_key_10_i,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic [WIDTH-1:0] rk_o,
    output logic [3:0]       rk_idx_o,
    output logic             rk_last_o,
    input  logic             rewind_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_STREAM,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_IDX    = 4'd10;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       idx_inc;
    logic             rk_valid_q, rk_valid_d;
    logic [WIDTH-1:0] kx_key_q, kx_key_d;
    logic [WIDTH-1:0] rk_q, rk_d;
    logic [WIDTH-1:0] store_q [0:10];
    logic [WIDTH-1:0] store_d [0:10];
    logic [WIDTH-1:0] kx_round [1:10];
    logic             key_accept;

    assign kx_round[1]  = kx_key_1_i;
    assign kx_round[2]  = kx_key_2_i;
    assign kx_round[3]  = kx_key_3_i;
    assign kx_round[4]  = kx_key_4_i;
    assign kx_round[5]  = kx_key_5_i;
    assign kx_round[6]  = kx_key_6_i;
    assign kx_round[7]  = kx_key_7_i;
    assign kx_round[8]  = kx_key_8_i;
    assign kx_round[9]  = kx_key_9_i;
    assign kx_round[10] = kx_key_10_i;

    // Gated by rst_n_i so the source sees "not ready" throughout reset even
    // though the state register already sits at IDLE.
    assign key_ready_o = rst_n_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign key_accept  = key_valid_i && key_ready_o;
    assign idx_inc     = idx_q + 4'd1;

    assign kx_key_o   = kx_key_q;
    assign rk_o       = rk_q;
    assign rk_idx_o   = idx_q;
    assign rk_valid_o = rk_valid_q;
    assign rk_last_o  = rk_valid_q && (idx_q == LAST_IDX);
    assign busy_o     = (state_q == ST_SETTLE) || (state_q == ST_STREAM);

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rk_valid_d = rk_valid_q;
        kx_key_d   = kx_key_q;
        rk_d       = rk_q;
        store_d    = store_q;

        // Accept is only possible in IDLE/DONE, and it beats a coincident rewind.
        if (key_accept) begin
            kx_key_d   = key_ciph_i;
            store_d[0] = key_ciph_i;
            cnt_d      = SETTLE_INIT;
            rk_valid_d = 1'b0;
            idx_d      = '0;
            state_d    = ST_SETTLE;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        for (int unsigned i = 1; i <= 10; i++) begin
                            store_d[i] = kx_round[i];
                        end
                        state_d    = ST_STREAM;
                        idx_d      = '0;
                        rk_d       = store_q[0];
                        rk_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_STREAM: begin
                    // Rewind takes priority over a same-cycle handshake.
                    if (rewind_i) begin
                        idx_d = '0;
                        rk_d  = store_q[0];
                    end else if (rk_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_d    = ST_DONE;
                            rk_valid_d = 1'b0;
                            idx_d      = '0;
                        end else begin
                            idx_d = idx_inc;
                            rk_d  = store_q[idx_inc];
                        end
                    end
                end
                ST_DONE: begin
                    if (rewind_i) begin
                        state_d    = ST_STREAM;
                        idx_d      = '0;
                        rk_d       = store_q[0];
                        rk_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            rk_valid_q <= 1'b0;
            kx_key_q   <= '0;
            rk_q       <= '0;
            for (int unsigned i = 0; i <= 10; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rk_valid_q <= rk_valid_d;
            kx_key_q   <= kx_key_d;
            rk_q       <= rk_d;
            store_q    <= store_d;
        end
    end

endmodule
